// File: rtl/dco_lock_ctrl.sv
// DCO frequency-lock controller: SAR search over gated edge-count windows, then a verify window.
// Optional continuous tracking in LOCKED when DCO_LOCK_TRACK_EN is defined.
module dco_lock_ctrl #(
    parameter int CODE_W = 8,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 256,
    parameter int SETTLE = 4,
    parameter int TOL    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  target,
    input  logic              dco_in,
    output logic [CODE_W-1:0] dco_code,
    output logic              dco_en,
    output logic              busy,
    output logic              locked,
    output logic              lock_fail,
    output logic              done,
    output logic [CNT_W-1:0]  meas
);
    localparam int CYC_W = $clog2(SETTLE + WINDOW + 1);
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] TOL_C       = CNT_W'(TOL);
`ifdef DCO_LOCK_TRACK_EN
    localparam logic [CYC_W-1:0] SETTLE_END  = CYC_W'(SETTLE);
    localparam logic [CYC_W-1:0] TRACK_LAST  = CYC_W'(SETTLE + WINDOW - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_VERIFY_S, S_VERIFY_M, S_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d, trial;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic [CNT_W-1:0]  meas_q, meas_d, tgt_q, tgt_d;
    logic              dco_q;
    logic              en_q, en_d, busy_q, busy_d, locked_q, locked_d;
    logic              fail_q, fail_d, done_q, done_d;
    logic              rise, counting, within_tol, launch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        sat_inc = (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Difference taken one bit wider than the operands so it never wraps.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = d[CNT_W] ? CNT_W'(-d) : CNT_W'(d);
    endfunction

    assign rise       = dco_in & ~dco_q;
    assign cnt_next   = sat_inc(cnt_q, rise);
    assign within_tol = (abs_diff(cnt_next, tgt_q) <= TOL_C);
    assign launch     = start && ((state_q == S_IDLE) || (state_q == S_LOCKED));
`ifdef DCO_LOCK_TRACK_EN
    assign counting = (state_q == S_MEASURE) || (state_q == S_VERIFY_M) ||
                      ((state_q == S_LOCKED) && (cyc_q >= SETTLE_END));
`else
    assign counting = (state_q == S_MEASURE) || (state_q == S_VERIFY_M);
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        trial    = code_q;
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        cnt_d    = counting ? cnt_next : cnt_q;
        meas_d   = meas_q;
        tgt_d    = tgt_q;
        en_d     = en_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        done_d   = 1'b0;

        case (state_q)
            S_SETTLE, S_VERIFY_S: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    cnt_d   = '0;
                    state_d = (state_q == S_SETTLE) ? S_MEASURE : S_VERIFY_M;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (cyc_q == WINDOW_LAST) begin
                    cyc_d   = '0;
                    meas_d  = cnt_next;
                    state_d = S_DECIDE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DECIDE: begin
                // Too few edges means the DCO is too slow: lower the code.
                if (meas_q < tgt_q) trial[idx_q] = 1'b0;
                if (idx_q != '0) begin
                    trial[idx_q - 1'b1] = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_VERIFY_S;
                end
                code_d = trial;
            end
            S_VERIFY_M: begin
                if (cyc_q == WINDOW_LAST) begin
                    cyc_d    = '0;
                    meas_d   = cnt_next;
                    locked_d = within_tol;
                    fail_d   = ~within_tol;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_LOCKED;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef DCO_LOCK_TRACK_EN
            S_LOCKED: begin
                if (cyc_q == TRACK_LAST) begin
                    cyc_d    = '0;
                    meas_d   = cnt_next;
                    locked_d = within_tol;
                    if (within_tol) begin
                        fail_d = 1'b0;
                    end else if ((cnt_next > tgt_q) && (code_q != '1)) begin
                        code_d = code_q + 1'b1;
                    end else if ((cnt_next < tgt_q) && (code_q != '0)) begin
                        code_d = code_q - 1'b1;
                    end
                end else begin
                    if (cyc_q == SETTLE_LAST) cnt_d = '0;
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            default: ;
        endcase

        if (launch) begin
            tgt_d    = target;
            idx_d    = IDX_W'(CODE_W - 1);
            code_d   = {1'b1, {(CODE_W-1){1'b0}}};
            en_d     = 1'b1;
            busy_d   = 1'b1;
            locked_d = 1'b0;
            fail_d   = 1'b0;
            cyc_d    = '0;
            cnt_d    = '0;
            state_d  = S_SETTLE;
        end

        // Abort wins over everything; code and last measurement are kept.
        if (stop) begin
            state_d  = S_IDLE;
            code_d   = code_q;
            meas_d   = meas_q;
            cyc_d    = '0;
            en_d     = 1'b0;
            busy_d   = 1'b0;
            locked_d = 1'b0;
            fail_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            idx_q    <= '0;
            cyc_q    <= '0;
            cnt_q    <= '0;
            meas_q   <= '0;
            tgt_q    <= '0;
            dco_q    <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            meas_q   <= meas_d;
            tgt_q    <= tgt_d;
            dco_q    <= dco_in;
            en_q     <= en_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
        end
    end

    assign dco_code  = code_q;
    assign dco_en    = en_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign lock_fail = fail_q;
    assign done      = done_q;
    assign meas      = meas_q;

endmodule

// File: tb/tb_dco_lock_ctrl.sv
// Scoreboard bench for dco_lock_ctrl against a DCO model with period 2*(code+1) cycles.
module tb_dco_lock_ctrl;
    localparam int DONE_CYC = 2349;  // (CODE_W+1)*(SETTLE+WINDOW) + CODE_W + 1 with defaults

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] target = 8'd0;
    logic       dco_in = 1'b0;
    logic [7:0] dco_code;
    logic       dco_en, busy, locked, lock_fail, done;
    logic [7:0] meas;

    dco_lock_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .target(target),
        .dco_in(dco_in), .dco_code(dco_code), .dco_en(dco_en), .busy(busy),
        .locked(locked), .lock_fail(lock_fail), .done(done), .meas(meas)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int ms;
        int lk;
        int fl;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    int   shift = 0;
    int   ph = 0;
    int   last_half = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // DCO model: low for half cycles then high for half cycles; phase restarts on any change.
    always @(negedge clk) begin
        int half;
        half = int'(dco_code) + 1 - shift;
        if (!dco_en || half != last_half) ph = 0;
        else ph = (ph + 1) % (2 * half);
        last_half = half;
        dco_in = dco_en && (ph >= half);
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int code, input int en, input int bz,
                            input int lk, input int fl, input int dn, input int ms);
        check({tag, ".code"},   32'(dco_code),  code);
        check({tag, ".en"},     32'(dco_en),    en);
        check({tag, ".busy"},   32'(busy),      bz);
        check({tag, ".locked"}, 32'(locked),    lk);
        check({tag, ".fail"},   32'(lock_fail), fl);
        check({tag, ".done"},   32'(done),      dn);
        check({tag, ".meas"},   32'(meas),      ms);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at edge %0d, expected no pulse", edge_cnt);
            end else begin
                e = sb.pop_front();
                check("done.cycle",  32'(edge_cnt),  e.at);
                check("done.code",   32'(dco_code),  e.code);
                check("done.meas",   32'(meas),      e.ms);
                check("done.locked", 32'(locked),    e.lk);
                check("done.fail",   32'(lock_fail), e.fl);
                check("done.busy",   32'(busy),      0);
            end
        end
    end

    task automatic run_search(input int tgt, input int code, input int ms, input int lk, input int fl);
        exp_t e;
        @(negedge clk);
        target = 8'(tgt);
        start  = 1'b1;
        e.code = code; e.ms = ms; e.lk = lk; e.fl = fl;
        e.at   = edge_cnt + 1 + DONE_CYC - 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("launch.busy", 32'(busy), 1);
        check("launch.code", 32'(dco_code), 128);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a;
        // Reset held with start asserted: nothing may happen.
        start  = 1'b1;
        target = 8'd16;
        repeat (3) @(negedge clk);
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_outs("idle", 0, 0, 0, 0, 0, 0, 0);

        run_search(16, 7, 16, 1, 0);
        wait_drain(3000);
        chk_outs("lock16", 7, 1, 0, 1, 0, 0, 16);

        // Restart from LOCKED with a new target.
        run_search(0, 255, 0, 1, 0);
        wait_drain(3000);
        chk_outs("lock0", 255, 1, 0, 1, 0, 0, 0);

        run_search(200, 0, 128, 0, 1);
        wait_drain(3000);
        chk_outs("fail200", 0, 1, 0, 0, 1, 0, 128);

        // Asynchronous reset mid-search.
        @(negedge clk);
        target = 8'd16;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stop during the third MEASURE window (cycles 527..782 after acceptance).
        @(negedge clk);
        target = 8'd16;
        start  = 1'b1;
        a = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < a + 599) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_outs("stop", 32, 0, 0, 0, 0, 0, 2);

        // Stop has priority over start.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_prio.busy", 32'(busy), 0);
        check("stop_prio.en", 32'(dco_en), 0);
        repeat (1800) @(negedge clk);

        run_search(16, 7, 16, 1, 0);
        wait_drain(3000);
        chk_outs("restart", 7, 1, 0, 1, 0, 0, 16);

        // A start pulse while busy must be ignored, including its target.
        run_search(16, 7, 16, 1, 0);
        repeat (1000) @(negedge clk);
        target = 8'd200;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start.busy", 32'(busy), 1);
        wait_drain(3000);
        chk_outs("busy_start", 7, 1, 0, 1, 0, 0, 16);

`ifdef DCO_LOCK_TRACK_EN
        // Speed the DCO up: code 7 now gives ~22 edges, code 9 gives exactly 16.
        shift = 2;
        begin
            int n = 0;
            while (!(dco_code == 8'd9 && locked) && n < 5000) begin
                @(negedge clk);
                n++;
            end
        end
        check("track.code", 32'(dco_code), 9);
        check("track.locked", 32'(locked), 1);
        check("track.fail", 32'(lock_fail), 0);
        check("track.meas", 32'(meas), 16);
        repeat (600) @(negedge clk);
        check("track.hold", 32'(dco_code), 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
